// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, timing helpers and parity.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_t;

  function automatic int cnt_width(input int cycles_per_bit);
    return (cycles_per_bit > 1) ? $clog2(cycles_per_bit) : 1;
  endfunction

  function automatic int half_bit(input int cycles_per_bit);
    return (cycles_per_bit - 1) / 2;
  endfunction

  // Zero-extension is harmless here: unused upper bits do not change the XOR.
  function automatic logic parity_of(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_vote.sv
// Two-flop synchroniser for the rx pin plus a 3-sample majority vote
// (two history flops and the live synchronised value).
module uart_sync_vote (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_vote
);

  logic [1:0] r_sync;
  logic [1:0] r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
      r_hist <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      r_hist <= {r_hist[0], r_sync[1]};
    end
  end

  assign o_rx_s = r_sync[1];
  assign o_vote = (r_hist[1] & r_hist[0]) |
                  (r_hist[1] & r_sync[1]) |
                  (r_hist[0] & r_sync[1]);

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable width, optional parity, 1/2 stop
// bits, majority-voted sampling, parity and framing error flags.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = 104,
  parameter int DATA_BITS      = 8,
  parameter int PARITY_EN      = 0,
  parameter int PARITY_ODD     = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 done,
  output logic [DATA_BITS-1:0] out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  // state  | meaning
  // IDLE   | line idle, waiting for a low rx_s
  // START  | half-bit wait, then re-check start bit (glitch filter)
  // DATA   | one window per payload bit, LSB first
  // PARITY | one window, compare vote with expected parity
  // STOP   | STOP_BITS windows; last one issues done

  localparam int CW = cnt_width(CYCLES_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] C_HALF = CW'(half_bit(CYCLES_PER_BIT));
  localparam logic [CW-1:0] C_LAST = CW'(CYCLES_PER_BIT - 1);
  localparam logic [IW-1:0] C_LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] C_LAST_STOP = IW'(STOP_BITS - 1);
  localparam logic          C_ODD = (PARITY_ODD != 0);

  uart_rx_state_t       r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bad;
  logic                 r_frm_bad;
  logic                 r_done;
  logic [DATA_BITS-1:0] r_out;
  logic                 r_perr;
  logic                 r_ferr;

  logic w_rx_s;
  logic w_vote;
  logic w_at_end;

  uart_sync_vote u_sync_vote (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_rx   (rx),
    .o_rx_s (w_rx_s),
    .o_vote (w_vote)
  );

  assign w_at_end = (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
      r_frm_bad <= 1'b0;
      r_done    <= 1'b0;
      r_out     <= '0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt     <= '0;
          r_idx     <= '0;
          r_par_bad <= 1'b0;
          r_frm_bad <= 1'b0;
          if (!w_rx_s) r_state <= START;
        end
        START: begin
          if (r_cnt == C_HALF) begin
            r_cnt   <= '0;
            r_state <= w_rx_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DATA: begin
          if (w_at_end) begin
            r_cnt <= '0;
            // Shift in from the top so the first (LSB) bit ends at position 0.
            r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
            if (r_idx == C_LAST_DATA) begin
              r_idx   <= '0;
              r_state <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        PARITY: begin
          if (w_at_end) begin
            r_cnt     <= '0;
            r_par_bad <= (w_vote != parity_of(9'(r_shift), C_ODD));
            r_state   <= STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        STOP: begin
          if (w_at_end) begin
            r_cnt <= '0;
            if (!w_vote) r_frm_bad <= 1'b1;
            if (r_idx == C_LAST_STOP) begin
              r_idx   <= '0;
              r_done  <= 1'b1;
              r_out   <= r_shift;
              r_perr  <= r_par_bad;
              r_ferr  <= r_frm_bad | ~w_vote;
              r_state <= IDLE;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign done       = r_done;
  assign out        = r_out;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = (r_state != IDLE);

endmodule
